// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - phase encoder and sequencing checker for an 8-bit one-hot ring
module ring_phase_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 4,
  parameter bit          DIR      = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       ring_in,
  input  logic             clear,
  output logic [2:0]       phase,
  output logic             valid,
  output logic             locked,
  output logic             step_err,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_count,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_LOCKING = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       prev_q;
  logic [3:0]       match_q, match_d;
  logic [2:0]       phase_q, phase_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             step_err_q, step_err_d;
  logic             rev_tick_q, rev_tick_d;
  logic [REV_W-1:0] rev_count_q, rev_count_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic       onehot;
  logic       step_ok;
  logic       rev_edge;
  logic [7:0] expected;
  logic [2:0] enc;

  assign onehot   = (ring_in != 8'h00) && ((ring_in & (ring_in - 8'd1)) == 8'h00);
  assign expected = DIR ? {prev_q[0], prev_q[7:1]} : {prev_q[6:0], prev_q[7]};
  assign step_ok  = onehot && (ring_in == expected);
  // Wrap point of a revolution: the step from the last bit back to the first.
  assign rev_edge = DIR ? ((ring_in == 8'h80) && (prev_q == 8'h01))
                        : ((ring_in == 8'h01) && (prev_q == 8'h80));

  always_comb begin
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ring_in[i]) enc = 3'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_SEARCH;
      match_q <= 4'd0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    case (state_q)
      S_SEARCH, S_FAULT: begin
        match_d = 4'd0;
        state_d = onehot ? S_LOCKING : S_SEARCH;
      end
      S_LOCKING: begin
        if (step_ok) begin
          match_d = match_q + 4'd1;
          if (match_q == 4'(LOCK_CNT - 1)) state_d = S_LOCKED;
        end else if (onehot) begin
          match_d = 4'd0;
        end else begin
          state_d = S_SEARCH;
        end
      end
      S_LOCKED: begin
        if (!step_ok) state_d = S_FAULT;
      end
      default: state_d = S_SEARCH;
    endcase
    if (clear) begin
      state_d = S_SEARCH;
      match_d = 4'd0;
    end
  end

  always_comb begin
    valid_d     = onehot;
    phase_d     = onehot ? enc : phase_q;
    locked_d    = (state_d == S_LOCKED);
    step_err_d  = (state_q == S_LOCKED) && !step_ok && !clear;
    rev_tick_d  = (state_q == S_LOCKED) && step_ok && rev_edge && !clear;
    rev_count_d = rev_count_q;
    err_count_d = err_count_q;
    if (clear) begin
      rev_count_d = '0;
      err_count_d = '0;
    end else begin
      if (rev_tick_d) rev_count_d = rev_count_q + REV_W'(1);
      if (step_err_d && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= 8'h00;
      phase_q     <= 3'd0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      step_err_q  <= 1'b0;
      rev_tick_q  <= 1'b0;
      rev_count_q <= '0;
      err_count_q <= '0;
    end else begin
      prev_q      <= ring_in;
      phase_q     <= phase_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      step_err_q  <= step_err_d;
      rev_tick_q  <= rev_tick_d;
      rev_count_q <= rev_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign phase     = phase_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign step_err  = step_err_q;
  assign rev_tick  = rev_tick_q;
  assign rev_count = rev_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - scoreboard bench for ring_phase_monitor, both rotation directions
module tb_ring_phase_monitor;

  localparam int MS = 0, ML = 1, MK = 2, MF = 3;
  localparam int LOCK = 4;

  typedef struct packed {
    logic [2:0] phase;
    logic       valid;
    logic       locked;
    logic       serr;
    logic       rtick;
    logic [7:0] rev;
    logic [3:0] err;
  } obs_t;

  typedef struct {
    int         st;
    int         match;
    logic [7:0] prev;
    logic [2:0] phase;
    logic       valid;
    logic       locked;
    logic       serr;
    logic       rtick;
    logic [7:0] rev;
    logic [3:0] err;
  } mdl_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] ring0, ring1;
  logic [2:0] phase0, phase1;
  logic       valid0, valid1, locked0, locked1, serr0, serr1, rtick0, rtick1;
  logic [7:0] rev0, rev1;
  logic [3:0] err0, err1;
  obs_t       o0, o1;

  int   checks = 0;
  int   failures = 0;
  mdl_t m0, m1;
  obs_t q0[$];
  obs_t q1[$];
  logic [7:0] b1;
  bit         b1_left;

  always #5 clock = ~clock;

  ring_phase_monitor #(.LOCK_CNT(LOCK), .REV_W(8), .ERR_W(4), .DIR(1'b0)) u_dir0 (
    .clock(clock), .reset(reset), .ring_in(ring0), .clear(clear),
    .phase(phase0), .valid(valid0), .locked(locked0), .step_err(serr0),
    .rev_tick(rtick0), .rev_count(rev0), .err_count(err0)
  );

  ring_phase_monitor #(.LOCK_CNT(LOCK), .REV_W(8), .ERR_W(4), .DIR(1'b1)) u_dir1 (
    .clock(clock), .reset(reset), .ring_in(ring1), .clear(clear),
    .phase(phase1), .valid(valid1), .locked(locked1), .step_err(serr1),
    .rev_tick(rtick1), .rev_count(rev1), .err_count(err1)
  );

  assign o0 = {phase0, valid0, locked0, serr0, rtick0, rev0, err0};
  assign o1 = {phase1, valid1, locked1, serr1, rtick1, rev1, err1};

  function automatic logic [7:0] rol(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] ror(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = MS; m.match = 0; m.prev = 8'h00; m.phase = 3'd0;
    m.valid = 1'b0; m.locked = 1'b0; m.serr = 1'b0; m.rtick = 1'b0;
    m.rev = 8'h00; m.err = 4'h0;
    return m;
  endfunction

  function automatic obs_t mout(input mdl_t m);
    obs_t o;
    o.phase = m.phase; o.valid = m.valid; o.locked = m.locked;
    o.serr = m.serr; o.rtick = m.rtick; o.rev = m.rev; o.err = m.err;
    return o;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic [7:0] r, input logic clr, input bit dir);
    mdl_t       n;
    bit         oh, ok, wrap;
    logic [7:0] ex;
    n    = m;
    oh   = ($countones(r) == 1);
    ex   = dir ? ror(m.prev) : rol(m.prev);
    ok   = oh && (r == ex);
    wrap = dir ? (r == 8'h80 && m.prev == 8'h01) : (r == 8'h01 && m.prev == 8'h80);
    n.prev  = r;
    n.valid = oh;
    if (oh) for (int i = 0; i < 8; i++) if (r[i]) n.phase = 3'(i);
    n.serr  = 1'b0;
    n.rtick = 1'b0;
    case (m.st)
      MS, MF: begin
        if (oh) begin n.st = ML; n.match = 0; end
        else n.st = MS;
      end
      ML: begin
        if (ok) begin
          n.match = m.match + 1;
          if (n.match == LOCK) n.st = MK;
        end else if (oh) n.match = 0;
        else n.st = MS;
      end
      default: begin
        if (ok) begin
          if (wrap) begin n.rtick = 1'b1; n.rev = m.rev + 8'd1; end
        end else begin
          n.st = MF; n.serr = 1'b1;
          if (m.err != 4'hF) n.err = m.err + 4'd1;
        end
      end
    endcase
    if (clr) begin
      n.st = MS; n.match = 0; n.rev = 8'h00; n.err = 4'h0; n.serr = 1'b0; n.rtick = 1'b0;
    end
    n.locked = (n.st == MK);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one sample into each DUT; dut1 follows its own free-running source.
  task automatic cyc(input logic [7:0] a, input logic clr);
    @(negedge clock);
    ring0 = a; ring1 = b1; clear = clr;
    m0 = mstep(m0, a, clr, 1'b0);
    m1 = mstep(m1, b1, clr, 1'b1);
    q0.push_back(mout(m0));
    q1.push_back(mout(m1));
    b1 = b1_left ? rol(b1) : ror(b1);
    @(posedge clock);
    #1;
    chk("dir0_outputs", 32'(o0), 32'(q0.pop_front()));
    chk("dir1_outputs", 32'(o1), 32'(q1.pop_front()));
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] v;
    reset = 1'b0; clear = 1'b0; ring0 = 8'h00; ring1 = 8'h00;
    m0 = mreset(); m1 = mreset();
    b1 = 8'h80; b1_left = 1'b0;
    #12;
    chk("reset_dir0", 32'(o0), 32'd0);
    chk("reset_dir1", 32'(o1), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    a = 8'h01;
    for (int i = 1; i <= 33; i++) begin
      cyc(a, 1'b0);
      if (i == 1) chk("edge1_valid_phase", {valid0, phase0}, {1'b1, 3'd0});
      if (i == 4) chk("edge4_not_locked", 32'(locked0), 32'd0);
      if (i == 5) chk("edge5_locked_both", {locked0, locked1}, 2'b11);
      if (i == 9) chk("edge9_rev_tick", {rtick0, rev0, rtick1, rev1}, {1'b1, 8'd1, 1'b1, 8'd1});
      a = rol(a);
    end
    chk("four_revs", {rev0, err0}, {8'd4, 4'd0});

    cyc(8'h00, 1'b0);
    chk("zero_fault", {valid0, phase0, serr0, locked0, err0}, {1'b0, 3'd0, 1'b1, 1'b0, 4'd1});
    a = 8'h02;
    for (int i = 0; i < 5; i++) begin
      cyc(a, 1'b0);
      a = rol(a);
    end
    chk("relocked", 32'(locked0), 32'd1);
    a = 8'h40;
    for (int i = 0; i < 5; i++) begin
      cyc(a, 1'b0);
      a = rol(a);
    end
    cyc(8'h10, 1'b0);
    chk("skip_fault", {serr0, err0}, {1'b1, 4'd2});
    cyc(8'h20, 1'b0);
    chk("after_skip_no_fault", {serr0, locked0}, 2'b00);

    for (int k = 0; k < 17; k++) begin
      for (int j = 0; j < 5; j++) begin
        v = 8'h01 << j;
        cyc(v, 1'b0);
      end
      cyc(8'h00, 1'b0);
    end
    chk("err_saturated", 32'(err0), 32'hF);
    cyc(8'h20, 1'b1);
    chk("clear", {err0, rev0, locked0, rev1, locked1}, {4'd0, 8'd0, 1'b0, 8'd0, 1'b0});

    a = 8'h01;
    for (int i = 0; i < 12; i++) begin
      cyc(a, 1'b0);
      a = rol(a);
    end
    chk("locked_before_reset", {locked0, ring0}, {1'b1, 8'h08});
    #2 reset = 1'b0;
    #1;
    chk("async_reset_dir0", 32'(o0), 32'd0);
    chk("async_reset_dir1", 32'(o1), 32'd0);
    m0 = mreset(); m1 = mreset();
    reset = 1'b1;

    b1 = 8'h01; b1_left = 1'b1;
    a = 8'h10;
    for (int i = 1; i <= 13; i++) begin
      cyc(a, 1'b0);
      chk("dir1_left_source_unlocked", 32'(locked1), 32'd0);
      if (i == 5) chk("relock_no_tick", {locked0, rtick0, serr0}, 3'b100);
      a = rol(a);
    end
    chk("tick_after_relock", {rtick0, rev0}, {1'b1, 8'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the 8-bit one-hot ring counter output. It encodes the active bit to a 3-bit phase index and checks that every sample is one-hot and is exactly one rotation step from the previous sample. It locks onto a healthy ring, counts full revolutions, and flags and counts sequencing faults. It is the stage that turns the raw ring vector into phase and health information for sequencing and status logic.

Parameters:
LOCK_CNT, 4, consecutive correct steps required in LOCKING before entering LOCKED (range 1..15)
REV_W, 8, width of rev_count
ERR_W, 4, width of err_count (saturating)
DIR, 0, rotation direction: 0 = rotate-left (bit0→bit1→…→bit7→bit0), 1 = rotate-right

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
ring_in  input  8  one-hot ring vector from upstream ring counter (registered upstream)
clear  input  1  synchronous clear of counters and FSM, active-high
phase  output  3  index of the set bit of last valid sample
valid  output  1  last sample was one-hot
locked  output  1  FSM in LOCKED
step_err  output  1  one-cycle pulse on a fault while LOCKED
rev_tick  output  1  one-cycle pulse on each completed revolution while LOCKED
rev_count  output  REV_W  revolutions completed, wraps modulo 2^REV_W
err_count  output  ERR_W  faults detected, saturates at all-ones

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (reset). All outputs are registered.
- Reset (reset=0): state SEARCH; prev register, phase, rev_count, err_count, match counter = 0; valid, locked, step_err, rev_tick = 0. Takes effect immediately, regardless of clock.
- Each rising edge samples ring_in and compares it with prev (the ring_in sampled at the previous edge). prev <= ring_in every edge. Outputs reflect the sample taken at the same edge, so latency is 1 clock.
- onehot = exactly one bit of ring_in set. expected = prev rotated by one bit per DIR.
- step_ok = onehot AND ring_in == expected.
- valid <= onehot. phase <= index of the set bit when onehot; otherwise phase holds its value.
- FSM states:
  - SEARCH: if onehot, go to LOCKING with match=0; else stay in SEARCH.
  - LOCKING:
    - step_ok: match++. If match reaches LOCK_CNT, go to LOCKED.
    - onehot but not step_ok: stay in LOCKING, match=0.
    - not onehot: go to SEARCH.
  - LOCKED:
    - step_ok: stay in LOCKED.
    - otherwise: go to FAULT, step_err=1 for one cycle, err_count+1 (saturating).
  - FAULT: lasts one cycle, then evaluates the current sample exactly as SEARCH does. A one-hot sample goes to LOCKING with match=0.
- locked=1 only in LOCKED; it drops in the same cycle step_err pulses.
- Revolution detection, active only in LOCKED with step_ok:
  - DIR=0: ring_in=8'h01 with prev=8'h80 → rev_tick=1, rev_count+1.
  - DIR=1: ring_in=8'h80 with prev=8'h01 → rev_tick=1, rev_count+1.
  - No rev_tick in SEARCH, LOCKING or FAULT.
- A repeated (stalled) value is a fault; all-zero and multi-hot samples are faults.
- clear=1 at an edge: state SEARCH, match=0, rev_count=0, err_count=0, step_err=0, rev_tick=0, locked=0. prev, phase and valid still update normally. clear overrides a fault or tick in the same cycle.
- Reset asserted mid-operation returns everything to reset values. On release, the first sample is compared against prev=0 and is treated as a SEARCH entry (no fault).

Test Plan:
- Reset release, upstream rotates-left from 8'h01, LOCK_CNT=4, DIR=0 → edge1 valid=1, phase=0, LOCKING. locked=1 after edge5 (sample 8'h10). First rev_tick at edge9 (8'h80→8'h01), rev_count=1. After 3 more revolutions, rev_count=4, err_count=0.
- While LOCKED, force ring_in=8'h00 for one cycle → valid=0, phase held, step_err=1, locked=0, err_count=1. FSM returns to LOCKING on the next one-hot sample, and locked=1 again 4 correct steps later.
- While LOCKED, inject a skip (8'h04→8'h10) → step_err=1, err_count+1. The next sample 8'h20 is a SEARCH-style entry (LOCKING), not a fault.
- Inject 17 faults → err_count saturates at 4'hF. Pulse clear → err_count=0, rev_count=0, state SEARCH.
- Assert reset mid-revolution at ring_in=8'h08 → all outputs 0 asynchronously. After release, no step_err and no rev_tick until locked again.
- DIR=1 with a right-rotating source from 8'h80 → locks after LOCK_CNT steps. rev_tick occurs on 8'h01→8'h80. A left-rotating source with DIR=1 never reaches LOCKED.
